branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline. It replaces the fixed predict-not-taken policy, which flushes the IF instruction on every taken branch. It is looked up combinationally with the IF-stage PC. It is trained by the ID stage, where branches resolve. It also counts resolved branches and mispredictions. Training uses a direct-mapped, tagged table of saturating counters plus branch targets.

---
 rtl/bp_pkg.sv | 34 +++
 rtl/sat_counter.sv | 20 ++
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: PC field extraction and counter constants.
package bp_pkg;

  localparam int unsigned STAT_W = 32;
  localparam int unsigned CTR_BITS_DEF = 2;

  function automatic int unsigned ctr_weak_nt(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned ctr_weak_t(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned ctr_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Constants for the default counter width; other widths use the functions above.
  localparam int unsigned CTR_WEAK_NT = ctr_weak_nt(CTR_BITS_DEF);
  localparam int unsigned CTR_WEAK_T  = ctr_weak_t(CTR_BITS_DEF);
  localparam int unsigned CTR_MAX     = ctr_max(CTR_BITS_DEF);

  // Word-aligned PCs: the two low bits never select an entry.
  function automatic logic [63:0] bp_index(input logic [63:0] pc, input int unsigned idx_bits);
    return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idx_bits,
                                         input int unsigned tag_bits);
    return (pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for an up/down counter that saturates at zero and all-ones.
module sat_counter #(
  parameter int unsigned Width = 2
) (
  input  logic [Width-1:0] val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] val_o
);

  always_comb begin
    val_o = val_i;
    if (inc_i && !dec_i && (val_i != {Width{1'b1}})) begin
      val_o = val_i + Width'(1);
    end else if (dec_i && !inc_i && (val_i != '0)) begin
      val_o = val_i - Width'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged bimodal branch predictor: combinational IF lookup, ID-stage training,
// and saturating branch/mispredict statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned MODE     = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_mispredict_i,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispredicts_o
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CtrWeakNt = CTR_BITS'(ctr_weak_nt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CtrWeakT  = CTR_BITS'(ctr_weak_t(CTR_BITS));

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [XLEN-1:0]     target_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

  logic [IDX-1:0]      lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                lk_hit, up_hit;
  logic [CTR_BITS-1:0] ctr_cur, ctr_nxt;

  assign lk_idx = IDX'(bp_index(64'(pc_i), IDX));
  assign lk_tag = TAG_BITS'(bp_tag(64'(pc_i), IDX, TAG_BITS));
  assign up_idx = IDX'(bp_index(64'(upd_pc_i), IDX));
  assign up_tag = TAG_BITS'(bp_tag(64'(upd_pc_i), IDX, TAG_BITS));

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = (MODE == 1) && lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target_o = target_q[lk_idx];

  assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign ctr_cur = ctr_q[up_idx];

  sat_counter #(
    .Width (CTR_BITS)
  ) u_ctr (
    .val_i (ctr_cur),
    .inc_i (upd_taken_i),
    .dec_i (!upd_taken_i),
    .val_o (ctr_nxt)
  );

  sat_counter #(
    .Width (STAT_W)
  ) u_stat_br (
    .val_i (stat_br_q),
    .inc_i (upd_valid_i),
    .dec_i (1'b0),
    .val_o (stat_br_d)
  );

  sat_counter #(
    .Width (STAT_W)
  ) u_stat_mp (
    .val_i (stat_mp_q),
    .inc_i (upd_valid_i && upd_mispredict_i),
    .dec_i (1'b0),
    .val_o (stat_mp_d)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid_i) begin
      if (up_hit) begin
        ctr_d[up_idx] = ctr_nxt;
        if (upd_taken_i) begin
          target_d[up_idx] = upd_target_i;
        end
      end else if (upd_taken_i) begin
        // Allocation evicts whatever occupied this index.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target_i;
        ctr_d[up_idx]    = CtrWeakT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CtrWeakNt;
      end
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      target_q  <= target_d;
      ctr_q     <= ctr_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a bimodal instance plus a static-not-taken instance.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  logic        pred_taken,  pred_taken0;
  logic [31:0] pred_target, pred_target0;
  logic [31:0] stat_br,  stat_br0;
  logic [31:0] stat_mp,  stat_mp0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  branch_predictor #(
    .XLEN(32), .ENTRIES(64), .TAG_BITS(8), .CTR_BITS(2), .MODE(1)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .pc_i               (pc),
    .pred_taken_o       (pred_taken),
    .pred_target_o      (pred_target),
    .upd_valid_i        (upd_valid),
    .upd_pc_i           (upd_pc),
    .upd_taken_i        (upd_taken),
    .upd_target_i       (upd_target),
    .upd_mispredict_i   (upd_mispredict),
    .stat_branches_o    (stat_br),
    .stat_mispredicts_o (stat_mp)
  );

  branch_predictor #(
    .XLEN(32), .ENTRIES(64), .TAG_BITS(8), .CTR_BITS(2), .MODE(0)
  ) dut0 (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .pc_i               (pc),
    .pred_taken_o       (pred_taken0),
    .pred_target_o      (pred_target0),
    .upd_valid_i        (upd_valid),
    .upd_pc_i           (upd_pc),
    .upd_taken_i        (upd_taken),
    .upd_target_i       (upd_target),
    .upd_mispredict_i   (upd_mispredict),
    .stat_branches_o    (stat_br0),
    .stat_mispredicts_o (stat_mp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                     input logic mp);
    upd_valid      = 1'b1;
    upd_pc         = p;
    upd_taken      = t;
    upd_target     = tgt;
    upd_mispredict = mp;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    do_reset();

    // Reset state
    pc = 32'h100; #1;
    check("reset_pred", 64'(pred_taken), 64'd0);
    check("reset_branches", 64'(stat_br), 64'd0);
    check("reset_mispredicts", 64'(stat_mp), 64'd0);
    check("reset_ctr", 64'(dut.ctr_q[0]), 64'd1);

    // Allocate on taken miss
    upd(32'h100, 1'b1, 32'h140, 1'b1);
    check("alloc_pred", 64'(pred_taken), 64'd1);
    check("alloc_target", 64'(pred_target), 64'h140);
    check("alloc_ctr", 64'(dut.ctr_q[0]), 64'd2);
    check("alloc_branches", 64'(stat_br), 64'd1);
    check("alloc_mispredicts", 64'(stat_mp), 64'd1);
    check("mode0_pred", 64'(pred_taken0), 64'd0);
    check("mode0_mispredicts", 64'(stat_mp0), 64'd1);

    // Saturation
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    check("nt1_ctr", 64'(dut.ctr_q[0]), 64'd1);
    check("nt1_pred", 64'(pred_taken), 64'd0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    check("nt2_ctr", 64'(dut.ctr_q[0]), 64'd0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    check("nt3_ctr_floor", 64'(dut.ctr_q[0]), 64'd0);
    check("nt3_pred", 64'(pred_taken), 64'd0);
    upd(32'h100, 1'b1, 32'h140, 1'b0);
    check("t1_ctr", 64'(dut.ctr_q[0]), 64'd1);
    check("t1_pred", 64'(pred_taken), 64'd0);
    upd(32'h100, 1'b1, 32'h140, 1'b0);
    upd(32'h100, 1'b1, 32'h140, 1'b0);
    upd(32'h100, 1'b1, 32'h144, 1'b0);
    check("t4_ctr_ceiling", 64'(dut.ctr_q[0]), 64'd3);
    check("t4_pred", 64'(pred_taken), 64'd1);
    check("t4_target", 64'(pred_target), 64'h144);
    check("sat_branches", 64'(stat_br), 64'd8);

    // Alias: 0x200 shares index 0 with tag 0x02
    pc = 32'h200; #1;
    check("alias_miss", 64'(pred_taken), 64'd0);
    pc = 32'h104; #1;
    check("other_idx_miss", 64'(pred_taken), 64'd0);
    upd(32'h200, 1'b1, 32'h300, 1'b0);
    pc = 32'h200; #1;
    check("alias_pred", 64'(pred_taken), 64'd1);
    check("alias_target", 64'(pred_target), 64'h300);
    pc = 32'h100; #1;
    check("evicted_miss", 64'(pred_taken), 64'd0);
    check("alias_branches", 64'(stat_br), 64'd9);
    check("mode0_branches", 64'(stat_br0), 64'd9);

    // Mid-run reset clears everything, then same-cycle hazard
    do_reset();
    pc = 32'h200; #1;
    check("rerun_pred_200", 64'(pred_taken), 64'd0);
    check("rerun_branches", 64'(stat_br), 64'd0);
    pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h140;
    #1;
    check("hazard_same_cycle", 64'(pred_taken), 64'd0);
    tick();
    upd_valid = 1'b0;
    check("hazard_next_cycle", 64'(pred_taken), 64'd1);
    check("mode0_trained_pred", 64'(pred_taken0), 64'd0);
    check("mode0_trained_ctr", 64'(dut0.ctr_q[0]), 64'd2);

    // Reset priority over a concurrent update
    rst_n = 1'b0;
    tick();
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    upd_target = 32'h140; upd_mispredict = 1'b1;
    tick();
    rst_n = 1'b1; upd_valid = 1'b0; upd_mispredict = 1'b0;
    #1;
    check("rstprio_pred", 64'(pred_taken), 64'd0);
    check("rstprio_valid", 64'(dut.valid_q[0]), 64'd0);
    check("rstprio_branches", 64'(stat_br), 64'd0);
    check("rstprio_mispredicts", 64'(stat_mp), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
